// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port B arbiter.
// Holds the FSM state encoding, default bus widths and the queued write-request layout.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // State names the owner of the next port B slot.
  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1,
    S_STEAL = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/dmem_wr_fifo.sv
// Keyboard write queue: strict FIFO, head visible combinationally, one-cycle push-to-head latency.
// Backpressure: push while full is ignored (caller flags it); pop while empty is ignored.
module dmem_wr_fifo
  import dmem_arb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wr_req_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic             core_clk,
  input  logic             resetn,
  input  logic             push_vld,
  input  entry_t           push_dat,
  input  logic             pop_rdy,
  output entry_t           head_dat,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  entry_t           ram [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = ram[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (do_push) ram[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Shares dmem port B between queued keyboard writes and VGA reads; port B registered, read tags RD_LAT+1 cycles.
// Backpressure: kb_ready drops when the queue is full (late writes dropped, overflow sticky); VGA waits at most MAX_WAIT.
module dmem_portb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int  ADDR_W     = ADDR_W_DEF,
  parameter int  DATA_W     = DATA_W_DEF,
  parameter int  FIFO_DEPTH = 4,
  parameter int  MAX_WAIT   = 64,
  parameter int  RD_LAT     = 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              kb_we,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_data,
  output logic              kb_ready,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_hold,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } kb_req_t;

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  kb_req_t           push_dat;
  kb_req_t           head_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              pop;
  logic              more_after_pop;
  logic              slot_rd_vld;
  logic              slot_stolen;
  logic [RD_LAT-1:0] tag_rd_sr;
  logic [RD_LAT-1:0] tag_st_sr;

  assign push_dat = '{addr: kb_addr, data: kb_data};
  assign push_ok  = kb_we && !fifo_full;
  assign kb_ready = !fifo_full;
  assign vga_data = mem_q;

  dmem_wr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (kb_req_t)
  ) u_wr_fifo (
    .core_clk (CLOCK_50),
    .resetn   (resetn),
    .push_vld (kb_we),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Occupancy once this cycle's pop and push have both taken effect.
  assign more_after_pop = (fifo_level > LVL_W'(1)) || push_ok;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_READ: begin
        if (!fifo_empty && !vga_rd_en) begin
          state_nxt = S_WRITE;
        end else if (!fifo_empty && (wait_cnt == WAIT_TOP)) begin
          state_nxt = S_STEAL;
        end
      end
      S_WRITE: begin
        pop       = !fifo_empty;
        state_nxt = (more_after_pop && !vga_rd_en) ? S_WRITE : S_READ;
      end
      S_STEAL: begin
        pop       = !fifo_empty;
        state_nxt = S_READ;
      end
      default: state_nxt = S_READ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= S_READ;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts how long a non-empty queue has gone without a slot; saturates at the steal threshold.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (fifo_empty || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_TOP) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      slot_rd_vld <= 1'b0;
      slot_stolen <= 1'b0;
    end else begin
      if (pop) begin
        mem_address <= head_dat.addr;
        mem_data    <= head_dat.data;
        mem_wren    <= 1'b1;
      end else begin
        mem_address <= vga_addr;
        mem_wren    <= 1'b0;
      end
      slot_rd_vld <= !pop && vga_rd_en;
      slot_stolen <= pop && vga_rd_en;
    end
  end

  // Tags follow the issued slot through the RAM read latency.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      tag_rd_sr <= '0;
      tag_st_sr <= '0;
    end else begin
      tag_rd_sr[0] <= slot_rd_vld;
      tag_st_sr[0] <= slot_stolen;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_rd_sr[i] <= tag_rd_sr[i-1];
        tag_st_sr[i] <= tag_st_sr[i-1];
      end
    end
  end

  assign vga_valid = tag_rd_sr[RD_LAT-1];
  assign vga_hold  = tag_st_sr[RD_LAT-1];

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (kb_we && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter: directed scenarios plus a randomized run against a queue/memory reference model.
module tb_dmem_portb_arbiter;

  localparam int DEPTH = 4;
  localparam int MAXW  = 64;

  logic        CLOCK_50;
  logic        resetn;
  logic        kb_we;
  logic [11:0] kb_addr;
  logic [31:0] kb_data;
  logic        kb_ready;
  logic        vga_rd_en;
  logic [11:0] vga_addr;
  logic [31:0] vga_data;
  logic        vga_valid;
  logic        vga_hold;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        overflow;
  logic [2:0]  fifo_level;

  int checks;
  int errors;

  logic [31:0] mem_arr   [0:4095];
  logic [31:0] model_mem [0:4095];

  dmem_portb_arbiter dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .kb_we       (kb_we),
    .kb_addr     (kb_addr),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .vga_rd_en   (vga_rd_en),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .vga_valid   (vga_valid),
    .vga_hold    (vga_hold),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Port B syncram, one cycle read latency, old data on a same-cycle write.
  always @(posedge CLOCK_50) begin
    if (mem_wren) mem_arr[mem_address] <= mem_data;
    mem_q <= mem_arr[mem_address];
  end

  task automatic do_reset(input int n);
    resetn = 1'b0;
    kb_we  = 1'b0;
    repeat (n) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    kb_we     = 1'b1;
    kb_addr   = 12'd5;
    kb_data   = 32'hdead_beef;
    vga_rd_en = 1'b1;
    vga_addr  = 12'd7;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (mem_wren !== 1'b0)       begin errors++; $display("FAIL reset_wren got %0b exp 0", mem_wren); end
    checks++; if (mem_address !== 12'd0)   begin errors++; $display("FAIL reset_addr got %0h exp 0", mem_address); end
    checks++; if (mem_data !== 32'd0)      begin errors++; $display("FAIL reset_data got %0h exp 0", mem_data); end
    checks++; if (vga_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %0b exp 0", vga_valid); end
    checks++; if (vga_hold !== 1'b0)       begin errors++; $display("FAIL reset_hold got %0b exp 0", vga_hold); end
    checks++; if (overflow !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    checks++; if (kb_ready !== 1'b1)       begin errors++; $display("FAIL reset_ready got %0b exp 1", kb_ready); end
    checks++; if (fifo_level !== 3'd0)     begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    kb_we  = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_write_readback();
    vga_rd_en = 1'b0;
    kb_we     = 1'b1;
    kb_addr   = 12'd36;
    kb_data   = 32'h49;
    @(negedge CLOCK_50);
    kb_we = 1'b0;
    checks++; if (fifo_level !== 3'd1 || mem_wren !== 1'b0)
      begin errors++; $display("FAIL wr_queued level %0d wren %0b exp 1 0", fifo_level, mem_wren); end
    @(negedge CLOCK_50);
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL wr_early got wren %0b exp 0", mem_wren); end
    @(negedge CLOCK_50);
    checks++; if (mem_wren !== 1'b1 || mem_address !== 12'd36 || mem_data !== 32'h49 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL wr_land wren %0b addr %0d data %0h level %0d exp 1 36 49 0", mem_wren, mem_address, mem_data, fifo_level); end
    vga_rd_en = 1'b1;
    vga_addr  = 12'd36;
    @(negedge CLOCK_50);
    checks++; if (mem_wren !== 1'b0 || mem_address !== 12'd36 || vga_valid !== 1'b0 || vga_hold !== 1'b0)
      begin errors++; $display("FAIL rd_issue wren %0b addr %0d valid %0b hold %0b exp 0 36 0 0", mem_wren, mem_address, vga_valid, vga_hold); end
    @(negedge CLOCK_50);
    checks++; if (vga_valid !== 1'b1 || vga_data !== 32'h49)
      begin errors++; $display("FAIL readback valid %0b data %0h exp 1 49", vga_valid, vga_data); end
    vga_rd_en = 1'b0;
  endtask

  // Queue becomes non-empty at the push edge, waits MAX_WAIT edges, then the next edge issues the stolen write.
  task automatic test_steal();
    logic [11:0] a;
    logic [31:0] d;
    int          steal_n;
    do_reset(2);
    a         = 12'h2a5;
    d         = $urandom;
    steal_n   = MAXW + 2;
    vga_rd_en = 1'b1;
    kb_we     = 1'b1;
    kb_addr   = a;
    kb_data   = d;
    for (int n = 1; n <= MAXW + 4; n++) begin
      vga_addr = 12'($urandom_range(0, 4095));
      @(negedge CLOCK_50);
      kb_we = 1'b0;
      checks++;
      if (mem_wren !== (n == steal_n))
        begin errors++; $display("FAIL steal_wren cycle %0d got %0b exp %0b", n, mem_wren, (n == steal_n)); end
      if (n == steal_n) begin
        checks++; if (mem_address !== a || mem_data !== d)
          begin errors++; $display("FAIL steal_entry addr %0h data %0h exp %0h %0h", mem_address, mem_data, a, d); end
      end else begin
        checks++; if (mem_address !== vga_addr)
          begin errors++; $display("FAIL steal_rd_addr cycle %0d got %0h exp %0h", n, mem_address, vga_addr); end
      end
      checks++;
      if (vga_hold !== (n == steal_n + 1))
        begin errors++; $display("FAIL steal_hold cycle %0d got %0b exp %0b", n, vga_hold, (n == steal_n + 1)); end
      if (n >= 2) begin
        checks++;
        if (vga_valid !== (n != steal_n + 1))
          begin errors++; $display("FAIL steal_valid cycle %0d got %0b exp %0b", n, vga_valid, (n != steal_n + 1)); end
      end
    end
    vga_rd_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    int          got;
    do_reset(2);
    vga_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      kb_we   = 1'b1;
      kb_addr = 12'(100 + i);
      kb_data = $urandom;
      if (i < DEPTH) begin ea.push_back(kb_addr); ed.push_back(kb_data); end
      @(negedge CLOCK_50);
      checks++;
      if (fifo_level !== 3'((i + 1 < DEPTH) ? i + 1 : DEPTH) || kb_ready !== (i + 1 < DEPTH) || overflow !== (i >= DEPTH))
        begin errors++; $display("FAIL ovf_fill%0d level %0d ready %0b ovf %0b", i, fifo_level, kb_ready, overflow); end
    end
    kb_we     = 1'b0;
    vga_rd_en = 1'b0;
    got       = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      if (mem_wren) begin
        checks++;
        if (got >= DEPTH) begin
          errors++; $display("FAIL ovf_extra_write addr %0h exp none", mem_address);
        end else if (mem_address !== ea[got] || mem_data !== ed[got]) begin
          errors++; $display("FAIL ovf_order%0d got %0h/%0h exp %0h/%0h", got, mem_address, mem_data, ea[got], ed[got]);
        end
        got++;
      end
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL ovf_drain_count got %0d exp %0d", got, DEPTH); end
    checks++; if (fifo_level !== 3'd0 || overflow !== 1'b1)
      begin errors++; $display("FAIL ovf_after level %0d ovf %0b exp 0 1", fifo_level, overflow); end
  endtask

  task automatic test_push_pop();
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    int          got;
    do_reset(2);
    vga_rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      kb_we   = 1'b1;
      kb_addr = 12'(200 + i);
      kb_data = $urandom;
      ea.push_back(kb_addr); ed.push_back(kb_data);
      @(negedge CLOCK_50);
    end
    kb_we     = 1'b0;
    vga_rd_en = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (fifo_level !== 3'd2 || mem_wren !== 1'b0)
      begin errors++; $display("FAIL pp_pre level %0d wren %0b exp 2 0", fifo_level, mem_wren); end
    kb_we   = 1'b1;
    kb_addr = 12'd202;
    kb_data = $urandom;
    ea.push_back(kb_addr); ed.push_back(kb_data);
    @(negedge CLOCK_50);
    kb_we = 1'b0;
    checks++; if (fifo_level !== 3'd2 || overflow !== 1'b0 || kb_ready !== 1'b1)
      begin errors++; $display("FAIL pp_level level %0d ovf %0b ready %0b exp 2 0 1", fifo_level, overflow, kb_ready); end
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_wren) begin
        checks++;
        if (got >= 3) begin
          errors++; $display("FAIL pp_extra_write addr %0h exp none", mem_address);
        end else if (mem_address !== ea[got] || mem_data !== ed[got]) begin
          errors++; $display("FAIL pp_order%0d got %0h/%0h exp %0h/%0h", got, mem_address, mem_data, ea[got], ed[got]);
        end
        got++;
      end
      @(negedge CLOCK_50);
    end
    checks++; if (got != 3 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL pp_drain count %0d level %0d exp 3 0", got, fifo_level); end
  endtask

  task automatic test_reset_mid_drain();
    logic seen_wr;
    do_reset(2);
    vga_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kb_we   = 1'b1;
      kb_addr = 12'(300 + i);
      kb_data = $urandom;
      @(negedge CLOCK_50);
    end
    kb_we     = 1'b0;
    vga_rd_en = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++; if (fifo_level !== 3'd3 || mem_wren !== 1'b1 || mem_address !== 12'd300)
      begin errors++; $display("FAIL mid_drain level %0d wren %0b addr %0d exp 3 1 300", fifo_level, mem_wren, mem_address); end
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    checks++; if (fifo_level !== 3'd0 || mem_wren !== 1'b0 || kb_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset level %0d wren %0b ready %0b exp 0 0 1", fifo_level, mem_wren, kb_ready); end
    seen_wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLOCK_50);
      if (mem_wren || fifo_level != 3'd0) seen_wr = 1'b1;
    end
    checks++; if (seen_wr !== 1'b0) begin errors++; $display("FAIL mid_discard got stale activity 1 exp 0"); end
  endtask

  task automatic test_random();
    logic [11:0] aq[$];
    logic [31:0] dq[$];
    int          size_pre;
    int          streak;
    int          mode;
    int          phase_left;
    logic        exp_ovf;
    logic        last_rd;
    logic        last_st;
    logic [11:0] last_addr;
    logic        this_rd;
    logic        this_st;
    do_reset(2);
    vga_rd_en = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    for (int i = 0; i < 4096; i++) model_mem[i] = mem_arr[i];
    exp_ovf    = 1'b0;
    streak     = 0;
    phase_left = 0;
    mode       = 0;
    last_rd    = 1'b0;
    last_st    = 1'b0;
    last_addr  = '0;
    for (int k = 0; k < 3000; k++) begin
      if (phase_left == 0) begin
        mode       = int'($urandom_range(0, 2));
        phase_left = int'($urandom_range(5, 160));
      end
      phase_left--;
      case (mode)
        0:       vga_rd_en = 1'b0;
        1:       vga_rd_en = 1'b1;
        default: vga_rd_en = ($urandom_range(0, 3) != 0);
      endcase
      kb_we    = ($urandom_range(0, 5) == 0);
      kb_addr  = 12'($urandom_range(0, 15));
      kb_data  = $urandom;
      vga_addr = 12'($urandom_range(0, 15));
      @(negedge CLOCK_50);
      size_pre = aq.size();
      checks++;
      if (vga_valid !== last_rd || vga_hold !== last_st)
        begin errors++; $display("FAIL rnd_tag k%0d valid %0b hold %0b exp %0b %0b", k, vga_valid, vga_hold, last_rd, last_st); end
      if (last_rd) begin
        checks++; if (vga_data !== model_mem[last_addr])
          begin errors++; $display("FAIL rnd_rdata k%0d addr %0h got %0h exp %0h", k, last_addr, vga_data, model_mem[last_addr]); end
      end
      this_rd = 1'b0;
      this_st = 1'b0;
      checks++;
      if (mem_wren) begin
        if (size_pre == 0) begin
          errors++; $display("FAIL rnd_pop_empty k%0d addr %0h exp no write", k, mem_address);
        end else begin
          if (mem_address !== aq[0] || mem_data !== dq[0])
            begin errors++; $display("FAIL rnd_order k%0d got %0h/%0h exp %0h/%0h", k, mem_address, mem_data, aq[0], dq[0]); end
          model_mem[aq[0]] = dq[0];
          void'(aq.pop_front());
          void'(dq.pop_front());
        end
        this_st = vga_rd_en;
      end else begin
        if (mem_address !== vga_addr)
          begin errors++; $display("FAIL rnd_rd_addr k%0d got %0h exp %0h", k, mem_address, vga_addr); end
        this_rd = vga_rd_en;
      end
      if (kb_we) begin
        if (size_pre < DEPTH) begin aq.push_back(kb_addr); dq.push_back(kb_data); end
        else exp_ovf = 1'b1;
      end
      if (size_pre > 0 && !mem_wren) streak++;
      else streak = 0;
      checks++; if (streak > MAXW)
        begin errors++; $display("FAIL rnd_starve k%0d waited %0d exp <= %0d", k, streak, MAXW); end
      checks++;
      if (fifo_level !== 3'(aq.size()) || kb_ready !== (aq.size() < DEPTH) || overflow !== exp_ovf)
        begin errors++; $display("FAIL rnd_status k%0d level %0d ready %0b ovf %0b exp %0d %0b %0b", k, fifo_level, kb_ready, overflow, aq.size(), (aq.size() < DEPTH), exp_ovf); end
      last_rd   = this_rd;
      last_st   = this_st;
      last_addr = vga_addr;
    end
    kb_we     = 1'b0;
    vga_rd_en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    kb_we     = 1'b0;
    kb_addr   = '0;
    kb_data   = '0;
    vga_rd_en = 1'b0;
    vga_addr  = '0;
    test_reset();
    test_write_readback();
    test_steal();
    test_overflow();
    test_push_pop();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
